i2si_rx_fifo: RTL
=================

I2SI_RX_FIFO -- requirements
Module: i2si_rx_fifo

Interface
REQ-001 Parameter DW, default 16, audio word width per channel.
REQ-002 Parameter DEPTH, default 8, number of stereo pair entries; power of two only.
REQ-003 clk  input  1  master clock (100 MHz system clock).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rf_i2si_en  input  1  receive enable from register file; low = flush.
REQ-006 in_lft  input  DW  left word from deserializer.
REQ-007 in_rgt  input  DW  right word from deserializer.
REQ-008 in_xfc  input  1  single-cycle transfer-complete pulse from deserializer; pair valid this cycle.
REQ-009 rd_req  input  1  consumer pop request.
REQ-010 rf_ovf_clr  input  1  single-cycle clear of sticky overflow flag.
REQ-011 rf_afull_thr  input  log2(DEPTH)+1  almost-full threshold, in entries.
REQ-012 out_lft  output  DW  head-entry left word.
REQ-013 out_rgt  output  DW  head-entry right word.
REQ-014 out_vld  output  1  head entry valid (FIFO not empty).
REQ-015 out_lvl  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 out_full  output  1  occupancy == DEPTH.
REQ-017 out_afull  output  1  occupancy >= rf_afull_thr.
REQ-018 out_ovf  output  1  sticky overflow flag.

Function
REQ-019 Show-ahead FIFO: out_lft/out_rgt SHALL present the oldest entry combinationally from storage whenever out_vld=1; values undefined-but-stable when out_vld=0.
REQ-020 Push: in_xfc=1 and rf_i2si_en=1 and (not full, or pop in same cycle) SHALL store {in_lft,in_rgt} at write pointer; visible on out_* one cycle later if FIFO was empty.
REQ-021 Pop: rd_req=1 and out_vld=1 SHALL advance read pointer at the clock edge; rd_req when out_vld=0 SHALL be ignored.
REQ-022 Simultaneous push+pop when full: both SHALL occur, out_lvl stays DEPTH, out_ovf unchanged.
REQ-023 Simultaneous push+pop when empty: pop ignored, push stored, out_lvl becomes 1.
REQ-024 Push when full without pop: pair SHALL be dropped, storage unchanged, out_ovf set next cycle.
REQ-025 out_ovf SHALL remain set until rf_ovf_clr=1; if set and clear coincide, set wins.
REQ-026 Pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full = MSBs differ and low bits equal; empty = pointers equal; wrap from DEPTH-1 to 0 seamless.
REQ-027 out_lvl SHALL equal write pointer minus read pointer modulo 2*DEPTH, registered-state derived, no extra latency.
REQ-028 rf_i2si_en=0 SHALL synchronously flush: both pointers to 0, out_ovf to 0, pushes and pops ignored while low; storage contents not cleared.
REQ-029 rf_afull_thr=0 SHALL make out_afull permanently 1; thresholds > DEPTH SHALL make it permanently 0.
REQ-030 in_xfc pulses are independent of sck timing; block SHALL accept a push every clk cycle.

Reset
REQ-031 rst=1 SHALL asynchronously force pointers to 0, out_vld=0, out_lvl=0, out_full=0, out_ovf=0; out_afull follows REQ-017/029 from out_lvl=0.
REQ-032 Storage array SHALL NOT be reset; out_lft/out_rgt reset value is don't-care.
REQ-033 Reset asserted mid-operation SHALL discard all entries; first push after release lands in entry 0.

Structure
REQ-034 Package i2si_pkg SHALL hold DW, DEPTH, PTR_W=log2(DEPTH)+1 and the stereo-pair struct {lft,rgt}.
REQ-035 One sub-module i2si_fifo_mem: DEPTH x 2*DW register file, one sync write port, one async read port, no reset.
REQ-036 Pointer/flag logic SHALL live in i2si_rx_fifo top; all outputs except out_lft/out_rgt driven from flops or simple compares of flops.

Verification
REQ-037 Reset release, push 0xAAAA/0xFFFF -> next cycle out_vld=1, out_lft=0xAAAA, out_rgt=0xFFFF, out_lvl=1.
REQ-038 Push 8 pairs (0x1478/0xA3B9 ... ) no pops -> out_full=1, out_lvl=8; 9th push 0x69D9/0xABCD -> dropped, out_ovf=1; pop 8 -> original order, 9th absent.
REQ-039 Full, push+pop same cycle -> out_lvl stays 8, out_ovf stays 0, head advances, new pair at tail.
REQ-040 Empty, push 0x0001/0xFFFF with rd_req=1 same cycle -> out_lvl=1, entry retained.
REQ-041 rf_afull_thr=6: levels 5->6 -> out_afull 0->1; rf_i2si_en dropped at level 6 -> out_lvl=0, out_vld=0, out_ovf=0 next cycle.
REQ-042 20 push/pop cycles wrapping pointers twice, random rd_req, rst pulsed at cycle 13 -> scoreboard matches, out_lvl=0 immediately on rst.

Source files
------------

// File: rtl/i2si_pkg.sv
// Shared sizing and data types for the I2S receive FIFO.
// PTR_W carries one extra wrap bit so full and empty can be told apart.
package i2si_pkg;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] lft;
    logic [DW-1:0] rgt;
  } i2si_pair_t;

endpackage

// File: rtl/i2si_fifo_mem.sv
// Stereo-pair storage: DEPTH x 2*DW register file.
// One synchronous write port and one asynchronous read port for show-ahead reads.
module i2si_fifo_mem #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [2*DW-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [2*DW-1:0] o_rdata
);

  logic [2*DW-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers alone, so
  // clearing it would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i2si_rx_fifo.sv
// Show-ahead receive FIFO for I2S stereo pairs with level, almost-full and
// sticky overflow reporting. DEPTH must be a power of two, at least 2.
module i2si_rx_fifo #(
  parameter int DW    = i2si_pkg::DW,
  parameter int DEPTH = i2si_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rf_i2si_en,
  input  logic [DW-1:0]            in_lft,
  input  logic [DW-1:0]            in_rgt,
  input  logic                     in_xfc,
  input  logic                     rd_req,
  input  logic                     rf_ovf_clr,
  input  logic [$clog2(DEPTH):0]   rf_afull_thr,
  output logic [DW-1:0]            out_lft,
  output logic [DW-1:0]            out_rgt,
  output logic                     out_vld,
  output logic [$clog2(DEPTH):0]   out_lvl,
  output logic                     out_full,
  output logic                     out_afull,
  output logic                     out_ovf
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [2*DW-1:0]  w_rdata;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop frees a slot in the same edge, so a full FIFO can still take a push.
  assign w_pop  = rf_i2si_en && rd_req && !w_empty;
  assign w_push = rf_i2si_en && in_xfc && (!w_full || w_pop);
  assign w_drop = rf_i2si_en && in_xfc && w_full && !w_pop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (!rf_i2si_en) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Overflow set takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!rf_i2si_en) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (rf_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  i2si_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata ({in_lft, in_rgt}),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign out_lft   = w_rdata[2*DW-1:DW];
  assign out_rgt   = w_rdata[DW-1:0];
  assign out_vld   = !w_empty;
  assign out_lvl   = r_wptr - r_rptr;
  assign out_full  = w_full;
  // Threshold 0 is always met and thresholds above DEPTH never are.
  assign out_afull = (out_lvl >= rf_afull_thr);
  assign out_ovf   = r_ovf;

endmodule
